// File: rtl/sram_axi4_pkg.sv
// Shared encodings and helpers for the SRAM AXI4 request bridge.
// Burst/resp codes, FSM state type and the response error test.
package sram_axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RSP
    } state_e;

    function automatic logic is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/sram_axi4_req.sv
// Single-outstanding bridge from a valid/ready load/store port to AXI4.
// Issues len-0 INCR transactions and returns data plus an error flag.
module sram_axi4_req
    import sram_axi4_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int ID_W = 4,
    parameter logic [ID_W-1:0] TXN_ID = ID_W'(1)
) (
    input  logic                i_aclk,
    input  logic                i_areset_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [2:0]          i_req_size,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [ID_W-1:0]     o_arid,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic [7:0]          o_arlen,
    output logic [2:0]          o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [ID_W-1:0]     i_rid,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic [ID_W-1:0]     o_awid,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_W-1:0]     i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2:0]            size_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic                  first_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  beat_err;
    logic                  aw_fin;
    logic                  w_fin;

    assign beat_err = is_err(i_rresp) || (i_rid != TXN_ID);
    assign aw_fin   = aw_done_q || i_awready;
    assign w_fin    = w_done_q || i_wready;

    // Handshake strobes decode straight from state and done flags.
    assign o_req_ready = (state_q == IDLE);
    assign o_arvalid   = (state_q == RD_ADDR);
    assign o_rready    = (state_q == RD_DATA);
    assign o_awvalid   = (state_q == WR_REQ) && !aw_done_q;
    assign o_wvalid    = (state_q == WR_REQ) && !w_done_q;
    assign o_bready    = (state_q == WR_RESP);
    assign o_rsp_valid = (state_q == RSP);

    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    assign o_arid    = TXN_ID;
    assign o_araddr  = addr_q;
    assign o_arlen   = 8'd0;
    assign o_arsize  = size_q;
    assign o_arburst = BURST_INCR;

    assign o_awid    = TXN_ID;
    assign o_awaddr  = addr_q;
    assign o_awlen   = 8'd0;
    assign o_awsize  = size_q;
    assign o_awburst = BURST_INCR;

    assign o_wdata = wdata_q;
    assign o_wstrb = wstrb_q;
    assign o_wlast = 1'b1;

    // Transaction FSM: captures the request, walks the AXI channels, holds the response.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            first_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q    <= i_req_addr;
                        size_q    <= i_req_size;
                        wdata_q   <= i_req_wdata;
                        wstrb_q   <= i_req_wstrb;
                        err_q     <= 1'b0;
                        first_q   <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= i_req_we ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (i_arready) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (i_rvalid) begin
                        if (first_q) begin
                            rdata_q <= i_rdata;
                            first_q <= 1'b0;
                        end
                        err_q <= err_q | beat_err;
                        if (i_rlast) state_q <= RSP;
                    end
                end
                WR_REQ: begin
                    if (i_awready) aw_done_q <= 1'b1;
                    if (i_wready) w_done_q <= 1'b1;
                    if (aw_fin && w_fin) state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (i_bvalid) begin
                        err_q   <= is_err(i_bresp) || (i_bid != TXN_ID);
                        rdata_q <= '0;
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi4_req.sv
// Bench for sram_axi4_req: AXI slave model, directed table and random traffic.
// Expected responses come from a word-array model of the memory.
module tb_sram_axi4_req;
    import sram_axi4_pkg::*;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [1:0]  resp;
        logic [3:0]  id;
        int          ar_d;
        int          aw_d;
        int          w_d;
        int          b_d;
        int          nbeats;
        int          hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        aclk;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [7:0]  i_req_addr;
    logic [2:0]  i_req_size;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [3:0]  o_arid;
    logic [7:0]  o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic        o_arvalid;
    logic        i_arready;
    logic [3:0]  i_rid;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rlast;
    logic        i_rvalid;
    logic        o_rready;
    logic [3:0]  o_awid;
    logic [7:0]  o_awaddr;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic        o_awvalid;
    logic        i_awready;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wlast;
    logic        o_wvalid;
    logic        i_wready;
    logic [3:0]  i_bid;
    logic [1:0]  i_bresp;
    logic        i_bvalid;
    logic        o_bready;

    sram_axi4_req dut (
        .i_aclk(aclk), .i_areset_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr),
        .i_req_size(i_req_size), .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen),
        .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
        .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
        .o_bready(o_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    vec_t        cur;
    logic [63:0] smem [32];
    logic [63:0] ref_mem [32];
    int          arcnt, awcnt, wcnt, bcnt, beat;
    int          aw_cyc, w_cyc, bviol;
    bit          r_pend, aw_seen, w_seen;
    logic [4:0]  ridx, widx;
    logic [63:0] w_data;
    logic [7:0]  w_strb;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [7:0] addr,
        input logic [63:0] wdata, input logic [7:0] wstrb,
        input logic [1:0] resp, input logic [3:0] id,
        input int d0, input int d1, input int d2,
        input int nb, input int hold,
        input logic [63:0] erd, input logic eerr, input int elat);
        vec_t v;
        v.we = we; v.addr = addr; v.size = 3'd3;
        v.wdata = wdata; v.wstrb = wstrb;
        v.resp = resp; v.id = id;
        v.ar_d = d0; v.aw_d = d0; v.w_d = d1; v.b_d = d2;
        v.nbeats = nb; v.hold = hold;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat;
        return v;
    endfunction

    // AXI slave model: counted ready delays, multi-beat reads, strobed writes.
    initial begin
        for (int i = 0; i < 32; i++) smem[i] = '0;
        {arcnt, awcnt, wcnt, bcnt, beat, bviol} = '0;
        {r_pend, aw_seen, w_seen} = '0;
        forever begin
            @(negedge aclk);
            i_arready = 1'b0; i_awready = 1'b0; i_wready = 1'b0;
            i_rvalid = 1'b0; i_rlast = 1'b0; i_bvalid = 1'b0;
            if (!rst_n) begin
                i_rdata = '0; i_rresp = '0; i_rid = '0;
                i_bresp = '0; i_bid = '0;
                {arcnt, awcnt, wcnt, bcnt, beat} = '0;
                {r_pend, aw_seen, w_seen} = '0;
            end else begin
                if (o_bready) begin
                    if (!(aw_seen && w_seen)) bviol++;
                    bcnt++;
                    if (bcnt > cur.b_d) begin
                        i_bvalid = 1'b1;
                        i_bresp = cur.resp;
                        i_bid = cur.id;
                        for (int b = 0; b < 8; b++)
                            if (w_strb[b])
                                smem[widx][8*b +: 8] = w_data[8*b +: 8];
                        aw_seen = 1'b0; w_seen = 1'b0; bcnt = 0;
                    end
                end
                if (r_pend && o_rready) begin
                    i_rvalid = 1'b1;
                    i_rdata = (beat == 0) ? smem[ridx] : 64'hB;
                    i_rresp = cur.resp;
                    i_rid = cur.id;
                    i_rlast = (beat == cur.nbeats - 1);
                    beat++;
                    if (i_rlast) r_pend = 1'b0;
                end
                if (o_arvalid) begin
                    arcnt++;
                    if (arcnt > cur.ar_d) begin
                        i_arready = 1'b1; arcnt = 0;
                        r_pend = 1'b1; beat = 0;
                        ridx = o_araddr[7:3];
                        chk("ar_fields",
                            {o_arid, o_arlen, o_arsize, o_arburst, o_araddr},
                            {4'd1, 8'd0, cur.size, BURST_INCR, cur.addr});
                    end
                end
                if (o_awvalid) begin
                    aw_cyc++; awcnt++;
                    if (awcnt > cur.aw_d) begin
                        i_awready = 1'b1; awcnt = 0; aw_seen = 1'b1;
                        widx = o_awaddr[7:3];
                        chk("aw_fields",
                            {o_awid, o_awlen, o_awsize, o_awburst, o_awaddr},
                            {4'd1, 8'd0, cur.size, BURST_INCR, cur.addr});
                    end
                end
                if (o_wvalid) begin
                    w_cyc++; wcnt++;
                    if (wcnt > cur.w_d) begin
                        i_wready = 1'b1; wcnt = 0; w_seen = 1'b1;
                        w_data = o_wdata; w_strb = o_wstrb;
                        chk("w_fields", {o_wlast, o_wstrb, o_wdata},
                            {1'b1, cur.wstrb, cur.wdata});
                    end
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        i_req_valid = 1'b1;
        i_req_we = v.we;
        i_req_addr = v.addr;
        i_req_size = v.size;
        i_req_wdata = v.wdata;
        i_req_wstrb = v.wstrb;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        cur = v;
        aw_cyc = 0; w_cyc = 0;
        i_rsp_ready = (v.hold == 0);
        cyc = 0;
        while (!o_req_ready && cyc < 50) begin
            @(negedge aclk); cyc++;
        end
        chk("req_ready_idle", o_req_ready, 1);
        drive_req(v);
        @(negedge aclk);
        i_req_valid = 1'b0;
        chk("req_ready_busy", o_req_ready, 0);
        cyc = 1;
        while (!o_rsp_valid && cyc < 100) begin
            @(negedge aclk); cyc++;
        end
        chk("rsp_valid", o_rsp_valid, 1);
        chk("latency", cyc, v.exp_lat);
        chk("rsp_rdata", o_rsp_rdata, v.exp_rdata);
        chk("rsp_err", o_rsp_err, v.exp_err);
        if (v.we) begin
            chk("aw_cycles", aw_cyc, v.aw_d + 1);
            chk("w_cycles", w_cyc, v.w_d + 1);
        end
        for (int h = 1; h < v.hold; h++) begin
            i_req_valid = 1'b1; i_req_we = 1'b0;
            @(negedge aclk);
            chk("hold_rsp", {o_rsp_valid, o_rsp_err, o_rsp_rdata},
                {1'b1, v.exp_err, v.exp_rdata});
            chk("hold_block", {o_req_ready, o_arvalid}, 2'b00);
        end
        i_rsp_ready = 1'b1;
        @(negedge aclk);
        i_req_valid = 1'b0;
        chk("rsp_done", {o_rsp_valid, o_req_ready}, 2'b01);
        if (v.we)
            for (int b = 0; b < 8; b++)
                if (v.wstrb[b])
                    ref_mem[v.addr[7:3]][8*b +: 8] = v.wdata[8*b +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [17];
        vec_t rv;
        int cyc;
        int mx;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        cur = mk(1'b0, 8'h0, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                 0, 0, 0, 1, 0, 64'h0, 1'b0, 0);
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_size = '0; i_req_wdata = '0; i_req_wstrb = '0;
        i_rsp_ready = 1'b1;
        #1;
        chk("reset_valids",
            {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_rsp_valid},
            6'b0);
        chk("reset_rsp", {o_req_ready, o_rsp_err, o_rsp_rdata},
            {1'b1, 1'b0, 64'h0});
        chk("reset_axi", {o_araddr, o_awaddr, o_wdata, o_wstrb}, '0);
        repeat (2) @(negedge aclk);
        rst_n = 1'b1;

        tbl[0]  = mk(1, 8'h10, 64'h1122334455667788, 8'hFF, RESP_OKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h0, 0, 3);
        tbl[1]  = mk(0, 8'h10, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h1122334455667788, 0, 3);
        tbl[2]  = mk(1, 8'h10, 64'hAABBCCDDEEFF0011, 8'h0F, RESP_EXOKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h0, 0, 3);
        tbl[3]  = mk(0, 8'h10, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h11223344EEFF0011, 0, 3);
        tbl[4]  = mk(0, 8'h10, 64'h0, 8'h0, RESP_SLVERR, 4'd1,
                     0, 0, 0, 1, 0, 64'h11223344EEFF0011, 1, 3);
        tbl[5]  = mk(0, 8'h10, 64'h0, 8'h0, RESP_OKAY, 4'd2,
                     0, 0, 0, 1, 0, 64'h11223344EEFF0011, 1, 3);
        tbl[6]  = mk(1, 8'h18, 64'h0123456789ABCDEF, 8'hFF, RESP_DECERR, 4'd1,
                     0, 0, 0, 1, 0, 64'h0, 1, 3);
        tbl[7]  = mk(0, 8'h18, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h0123456789ABCDEF, 0, 3);
        tbl[8]  = mk(1, 8'h20, 64'h5555AAAA5555AAAA, 8'hFF, RESP_OKAY, 4'd1,
                     3, 0, 0, 1, 0, 64'h0, 0, 6);
        tbl[9]  = mk(1, 8'h28, 64'hA, 8'hFF, RESP_OKAY, 4'd1,
                     0, 2, 0, 1, 0, 64'h0, 0, 5);
        tbl[10] = mk(0, 8'h20, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     2, 0, 0, 1, 0, 64'h5555AAAA5555AAAA, 0, 5);
        tbl[11] = mk(0, 8'h28, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     0, 0, 0, 2, 0, 64'hA, 0, 4);
        tbl[12] = mk(1, 8'h30, 64'hDEADBEEF00000000, 8'hF0, RESP_OKAY, 4'd1,
                     0, 0, 3, 1, 0, 64'h0, 0, 6);
        tbl[13] = mk(0, 8'h30, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                     0, 0, 0, 1, 5, 64'hDEADBEEF00000000, 0, 3);
        tbl[14] = mk(1, 8'h38, 64'h77, 8'h01, RESP_OKAY, 4'd2,
                     0, 0, 0, 1, 0, 64'h0, 1, 3);
        tbl[15] = mk(0, 8'h10, 64'h0, 8'h0, RESP_EXOKAY, 4'd1,
                     0, 0, 0, 1, 0, 64'h11223344EEFF0011, 0, 3);
        tbl[16] = mk(0, 8'h08, 64'h0, 8'h0, RESP_DECERR, 4'd1,
                     0, 0, 0, 1, 0, 64'h0, 1, 3);
        for (int i = 0; i < 17; i++) run_vec(tbl[i]);

        // Reset while waiting for B: everything drops at once.
        cur = mk(1, 8'h40, 64'hFFFF, 8'hFF, RESP_OKAY, 4'd1,
                 0, 0, 20, 1, 0, 64'h0, 0, 0);
        i_rsp_ready = 1'b1;
        drive_req(cur);
        @(negedge aclk);
        i_req_valid = 1'b0;
        cyc = 0;
        while (!o_bready && cyc < 50) begin
            @(negedge aclk); cyc++;
        end
        chk("rst_pre_bready", o_bready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valids",
            {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_rsp_valid},
            6'b0);
        chk("rst_mid_regs", {o_req_ready, o_rsp_err, o_awaddr, o_wdata},
            {1'b1, 1'b0, 8'h0, 64'h0});
        repeat (2) @(negedge aclk);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", o_req_ready, 1);
        run_vec(mk(0, 8'h10, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                   0, 0, 0, 1, 0, 64'h11223344EEFF0011, 0, 3));
        run_vec(mk(0, 8'h40, 64'h0, 8'h0, RESP_OKAY, 4'd1,
                   0, 0, 0, 1, 0, 64'h0, 0, 3));

        // Random traffic against the word-array model.
        for (int k = 0; k < 200; k++) begin
            rv.we = 1'($urandom);
            rv.addr = 8'($urandom);
            rv.size = 3'($urandom);
            rv.wdata = {32'($urandom), 32'($urandom)};
            rv.wstrb = 8'($urandom);
            rv.resp = 2'($urandom);
            rv.id = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd1;
            rv.ar_d = int'($urandom_range(0, 2));
            rv.aw_d = int'($urandom_range(0, 3));
            rv.w_d = int'($urandom_range(0, 3));
            rv.b_d = int'($urandom_range(0, 3));
            rv.nbeats = int'($urandom_range(1, 3));
            rv.hold = int'($urandom_range(0, 2));
            rv.exp_err = rv.resp[1] | (rv.id != 4'd1);
            rv.exp_rdata = rv.we ? 64'h0 : ref_mem[rv.addr[7:3]];
            mx = (rv.aw_d > rv.w_d) ? rv.aw_d : rv.w_d;
            rv.exp_lat = rv.we ? 3 + mx + rv.b_d
                               : 3 + rv.ar_d + rv.nbeats - 1;
            run_vec(rv);
        end

        chk("bready_before_done", bviol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_axi4_req.md
# sram_axi4_req

Upstream request bridge for the SRAM AXI4 slave. Accepts single-beat load/store requests on a simple valid/ready port, such as from a core LSU or DMA, and issues them as AXI4 single-beat transactions with len 0 and INCR bursts. It returns read data and an error flag on a valid/ready response port, with one transaction outstanding at a time.

## Interface
Parameters:
- ADDR_W, 8, byte address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- ID_W, 4, AXI ID width.
- TXN_ID, 1, constant ID driven on AR/AW; expected on R/B.

Ports (clock and reset first; grouped bullets list widths in signal order):
- i_aclk  in  1  single clock, rising edge.
- i_areset_n  in  1  asynchronous active-low reset.
- i_req_valid / o_req_ready  in/out  1/1  request handshake.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr / i_req_size  in  ADDR_W/3  byte address; AXI size code.
- i_req_wdata / i_req_wstrb  in  DATA_W/DATA_W/8  store data and strobes.
- o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
- o_rsp_rdata / o_rsp_err  out  DATA_W/1  load data (0 for stores); error flag.
- o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid / i_arready  out/in  ID_W, ADDR_W, 8, 3, 2, 1 / 1  AR channel.
- i_rid, i_rdata, i_rresp, i_rlast, i_rvalid / o_rready  in/out  ID_W, DATA_W, 2, 1, 1 / 1  R channel.
- o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid / i_awready  out/in  ID_W, ADDR_W, 8, 3, 2, 1 / 1  AW channel.
- o_wdata, o_wstrb, o_wlast, o_wvalid / i_wready  out/in  DATA_W, DATA_W/8, 1, 1 / 1  W channel.
- i_bid, i_bresp, i_bvalid / o_bready  in/out  ID_W, 2, 1 / 1  B channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE: o_req_ready=1. On i_req_valid, register addr/size/wdata/wstrb/we, clear err, go to RD_ADDR (we=0) or WR_REQ (we=1).
- RD_ADDR: o_arvalid=1, held stable until i_arready, then go to RD_DATA.
- RD_DATA: o_rready=1. Data is captured from the first beat. err |= (i_rresp[1] | i_rid!=TXN_ID) on every beat. Leave to RSP on the beat with i_rlast; extra beats are drained and ignored.
- WR_REQ: o_awvalid and o_wvalid both rise on entry. Each drops independently on its own handshake, tracked by aw_done/w_done flags. W may complete before AW. Go to WR_RESP the cycle both are done, including the same-cycle case.
- WR_RESP: o_bready=1. On i_bvalid, err = i_bresp[1] | i_bid!=TXN_ID, rdata=0, go to RSP.
- RSP: o_rsp_valid=1, data stable until i_rsp_ready, then IDLE.
- Constant fields: arlen/awlen=0, arburst/awburst=INCR (2'b01), wlast=1, IDs=TXN_ID. Size is passed through from i_req_size. OKAY and EXOKAY are not errors; SLVERR and DECERR are.

## Timing
- All outputs are registered or decoded from state. There is no combinational path from the request port to AXI or from AXI to the response port.
- Read, zero-wait slave: req accepted at cycle 0; arvalid at 1; ar handshake at 1; rready at 2; rvalid at 2; rsp_valid at 3.
- Write, zero-wait: awvalid/wvalid at 1; bready at 2; rsp_valid at 3 (or later per B latency).
- o_req_ready=0 from the cycle after acceptance until return to IDLE. The next request is accepted no earlier than the cycle after the rsp handshake.
- Reset, asynchronous: state IDLE. o_req_ready=1 after reset release (combinational from IDLE). All valids/readies 0. o_rsp_rdata=0, o_rsp_err=0. Registered AXI address/data = 0.
- Reset mid-transaction abandons it immediately. The slave must be reset together with this block.

## Structure
- sram_axi4_pkg holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp encodings (OKAY/EXOKAY/SLVERR/DECERR);
  - the state enum typedef;
  - an is_err(resp) function.
- Single module. No sub-module is needed; the AW/W done tracking is two flops inside the FSM.

## Test plan
- Store addr 0x10, wdata 0x1122334455667788, wstrb 0xFF, slave OKAY -> one AW and one W (wlast=1), rsp_valid with err=0 at cycle 3. A following load of 0x10 returns 0x1122334455667788.
- Slave delays awready 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, bready only after both complete.
- Load with slave returning rresp=SLVERR -> rsp_err=1. Load returning rid=2 -> rsp_err=1.
- rsp_ready held low 5 cycles -> rsp_valid and rdata stable, req_ready=0; a second i_req_valid is not accepted until after the handshake.
- Slave returns 2 R beats (0xA, then 0xB with rlast) -> rdata=0xA, a single response.
- Assert reset during WR_RESP -> all valids 0 immediately. After release, req_ready=1 and a new load completes normally.
